// File: rtl/aes_128_sched_pkg.sv
// Shared widths and types for the two-requester AES-128 scheduler.
package aes_128_sched_pkg;

    localparam int unsigned AES_W           = 128;
    localparam int unsigned AES_LATENCY_DEF = 21;
    localparam int unsigned ID_W            = 1;
    localparam int unsigned IN_FLIGHT_W     = 5;
    localparam int unsigned STAT_W          = 32;

    // One tag pipeline stage: job present + owning requester.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/aes_128.sv
// Fully pipelined AES-128 encryption core: one input register, ten round
// stages, then a pad delay so the total is LATENCY clk edges (LATENCY >= 11).
// The data pipeline has no reset; ownership of results is tracked outside.
module aes_128
    import aes_128_sched_pkg::*;
#(
    parameter int unsigned LATENCY = AES_LATENCY_DEF
) (
    input  logic             clk,
    input  logic [AES_W-1:0] state,
    input  logic [AES_W-1:0] key,
    output logic [AES_W-1:0] out
);

    localparam int unsigned ROUNDS = 10;
    localparam int unsigned PAD    = LATENCY - ROUNDS - 1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [AES_W-1:0] next_key(input logic [AES_W-1:0] k,
                                                  input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
             ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // SubBytes, ShiftRows, MixColumns (skipped in the final round), AddRoundKey.
    function automatic logic [AES_W-1:0] aes_round(input logic [AES_W-1:0] s,
                                                   input logic [AES_W-1:0] rk,
                                                   input logic last);
        logic [7:0]       sb [16];
        logic [7:0]       sr [16];
        logic [7:0]       a0, a1, a2, a3;
        logic [AES_W-1:0] o;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ rk;
    endfunction

    logic [AES_W-1:0] st_q [ROUNDS+1];
    logic [AES_W-1:0] st_d [ROUNDS+1];
    logic [AES_W-1:0] k_q  [ROUNDS];
    logic [AES_W-1:0] k_d  [ROUNDS];

    // Round datapath: each stage expands its round key on the fly.
    always_comb begin : p_round
        logic [7:0]       rc;
        logic [AES_W-1:0] rk;
        st_d[0] = state ^ key;
        k_d[0]  = key;
        rc      = 8'h01;
        rk      = '0;
        for (int unsigned r = 1; r <= ROUNDS; r++) begin
            rk      = next_key(k_q[r-1], rc);
            st_d[r] = aes_round(st_q[r-1], rk, r == ROUNDS);
            if (r < ROUNDS) k_d[r] = rk;
            rc      = xtime(rc);
        end
    end

    // Round stage registers.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r <= ROUNDS; r++) st_q[r] <= st_d[r];
        for (int unsigned r = 0; r < ROUNDS; r++)  k_q[r]  <= k_d[r];
    end

    generate
        if (PAD == 0) begin : g_nopad
            assign out = st_q[ROUNDS];
        end else begin : g_pad
            logic [AES_W-1:0] pad_q [PAD];
            // Output delay line to reach the advertised latency.
            always_ff @(posedge clk) begin
                pad_q[0] <= st_q[ROUNDS];
                for (int unsigned i = 1; i < PAD; i++) pad_q[i] <= pad_q[i-1];
            end
            assign out = pad_q[PAD-1];
        end
    endgenerate

endmodule

// File: rtl/aes_128_sched.sv
// Round-robin scheduler sharing one pipelined aes_128 core between two
// requesters; a tag pipeline routes each result back to its owner.
// Optional per-requester accept counters: define AES_128_SCHED_STATS_EN.
module aes_128_sched
    import aes_128_sched_pkg::*;
#(
    parameter int unsigned AES_LATENCY = AES_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [AES_W-1:0]       req0_state,
    input  logic [AES_W-1:0]       req0_key,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [AES_W-1:0]       req1_state,
    input  logic [AES_W-1:0]       req1_key,
    output logic                   resp0_valid,
    output logic [AES_W-1:0]       resp0_data,
    output logic                   resp1_valid,
    output logic [AES_W-1:0]       resp1_data,
    output logic [IN_FLIGHT_W-1:0] in_flight,
    output logic                   busy
`ifdef AES_128_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]      stat_grant0,
    output logic [STAT_W-1:0]      stat_grant1
`endif
);

    logic [ID_W-1:0]        prio_q, prio_d;
    tag_t                   tag_q [AES_LATENCY];
    tag_t                   tag_d [AES_LATENCY];
    logic [IN_FLIGHT_W-1:0] in_flight_q, in_flight_d;

    logic                   accept_c;
    logic [ID_W-1:0]        gnt_id_c;
    logic                   resp_hit_c;
    logic [AES_W-1:0]       core_state_c, core_key_c, core_out;

    // Arbiter: lone requester wins; on contention the priority pointer decides.
    always_comb begin
        accept_c = 1'b0;
        gnt_id_c = '0;
        if (!rst && en) begin
            if (req0_valid && req1_valid) begin
                accept_c = 1'b1;
                gnt_id_c = prio_q;
            end else if (req0_valid) begin
                accept_c = 1'b1;
            end else if (req1_valid) begin
                accept_c = 1'b1;
                gnt_id_c = ID_W'(1);
            end
        end
    end

    assign req0_ready = accept_c && (gnt_id_c == '0);
    assign req1_ready = accept_c && (gnt_id_c == ID_W'(1));

    // Core inputs carry the accepted job, otherwise zero.
    always_comb begin
        core_state_c = '0;
        core_key_c   = '0;
        if (accept_c) begin
            core_state_c = (gnt_id_c == '0) ? req0_state : req1_state;
            core_key_c   = (gnt_id_c == '0) ? req0_key   : req1_key;
        end
    end

    aes_128 #(
        .LATENCY (AES_LATENCY)
    ) u_core (
        .clk   (clk),
        .state (core_state_c),
        .key   (core_key_c),
        .out   (core_out)
    );

    assign resp_hit_c  = !rst && tag_q[AES_LATENCY-1].vld;
    assign resp0_valid = resp_hit_c && (tag_q[AES_LATENCY-1].id == '0);
    assign resp1_valid = resp_hit_c && (tag_q[AES_LATENCY-1].id == ID_W'(1));
    assign resp0_data  = resp0_valid ? core_out : '0;
    assign resp1_data  = resp1_valid ? core_out : '0;
    assign in_flight   = rst ? '0 : in_flight_q;
    assign busy        = (in_flight != '0);

    // Next state: tag shift, pointer update on accept, in-flight accounting.
    always_comb begin
        tag_d[0].vld = accept_c;
        tag_d[0].id  = gnt_id_c;
        for (int unsigned i = 1; i < AES_LATENCY; i++) tag_d[i] = tag_q[i-1];
        prio_d      = accept_c ? ~gnt_id_c : prio_q;
        in_flight_d = in_flight_q;
        if (accept_c && !resp_hit_c)      in_flight_d = in_flight_q + IN_FLIGHT_W'(1);
        else if (!accept_c && resp_hit_c) in_flight_d = in_flight_q - IN_FLIGHT_W'(1);
    end

    // Control state registers; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= '0;
            in_flight_q <= '0;
            for (int unsigned i = 0; i < AES_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            prio_q      <= prio_d;
            in_flight_q <= in_flight_d;
            for (int unsigned i = 0; i < AES_LATENCY; i++) tag_q[i] <= tag_d[i];
        end
    end

`ifdef AES_128_SCHED_STATS_EN
    logic [STAT_W-1:0] stat0_q, stat0_d, stat1_q, stat1_d;

    // Saturating accept counters per requester.
    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (req0_ready && (stat0_q != '1)) stat0_d = stat0_q + STAT_W'(1);
        if (req1_ready && (stat1_q != '1)) stat1_d = stat1_q + STAT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat_grant0 = stat0_q;
    assign stat_grant1 = stat1_q;
`endif

endmodule

// File: tb/tb_aes_128_sched.sv
// Scoreboard bench for aes_128_sched using published AES-128 test vectors.
module tb_aes_128_sched;
    import aes_128_sched_pkg::*;

    localparam int unsigned LAT = 21;
    localparam int unsigned NV  = 7;

    logic                   clk = 1'b0;
    logic                   rst, en;
    logic                   req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AES_W-1:0]       req0_state, req0_key, req1_state, req1_key;
    logic                   resp0_valid, resp1_valid;
    logic [AES_W-1:0]       resp0_data, resp1_data;
    logic [IN_FLIGHT_W-1:0] in_flight;
    logic                   busy;
`ifdef AES_128_SCHED_STATS_EN
    logic [STAT_W-1:0]      stat_grant0, stat_grant1;
`endif

    always #5 clk = ~clk;

    int unsigned now = 0;
    always @(posedge clk) now <= now + 1;

    aes_128_sched #(.AES_LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_state  (req0_state),
        .req0_key    (req0_key),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_state  (req1_state),
        .req1_key    (req1_key),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .in_flight   (in_flight),
        .busy        (busy)
`ifdef AES_128_SCHED_STATS_EN
        ,
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1)
`endif
    );

    typedef struct {
        logic             id;
        logic [AES_W-1:0] data;
        int unsigned      due;
    } exp_t;

    exp_t             sb [$];
    logic [AES_W-1:0] vk [NV];
    logic [AES_W-1:0] vp [NV];
    logic [AES_W-1:0] vc [NV];
    int unsigned      vi0 = 0, vi1 = 3;
    logic             prio_m = 1'b0;
    int unsigned      cnt0 = 0, cnt1 = 0;
    int unsigned      peak = 0;
    int               errors = 0, checks = 0;

    task automatic check_eq(input string tag, input logic [AES_W-1:0] got,
                            input logic [AES_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, now, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check all outputs against the model, advance.
    task automatic cyc(input logic r, input logic e, input logic a, input logic b);
        logic             er0, er1, ev0, ev1;
        logic [AES_W-1:0] ed0, ed1;
        int unsigned      exp_if;
        rst        = r;
        en         = e;
        req0_valid = a;
        req1_valid = b;
        req0_state = vp[vi0];
        req0_key   = vk[vi0];
        req1_state = vp[vi1];
        req1_key   = vk[vi1];
        #1;
        exp_if = r ? 0 : int'(sb.size());
        check_eq("in_flight", AES_W'(in_flight), AES_W'(exp_if));
        check_eq("busy", AES_W'(busy), AES_W'(exp_if != 0));
        if (int'(in_flight) > int'(peak)) peak = int'(in_flight);
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        if (sb.size() != 0 && sb[0].due == now) begin
            if (!r) begin
                if (sb[0].id) begin ev1 = 1'b1; ed1 = sb[0].data; end
                else          begin ev0 = 1'b1; ed0 = sb[0].data; end
            end
            void'(sb.pop_front());
        end
        check_eq("resp0_valid", AES_W'(resp0_valid), AES_W'(ev0));
        check_eq("resp0_data", resp0_data, ed0);
        check_eq("resp1_valid", AES_W'(resp1_valid), AES_W'(ev1));
        check_eq("resp1_data", resp1_data, ed1);
        er0 = 1'b0; er1 = 1'b0;
        if (!r && e) begin
            if (a && b) begin
                if (prio_m) er1 = 1'b1; else er0 = 1'b1;
            end else if (a) er0 = 1'b1;
            else if (b)     er1 = 1'b1;
        end
        check_eq("req0_ready", AES_W'(req0_ready), AES_W'(er0));
        check_eq("req1_ready", AES_W'(req1_ready), AES_W'(er1));
`ifdef AES_128_SCHED_STATS_EN
        if (!r) begin
            check_eq("stat_grant0", AES_W'(stat_grant0), AES_W'(cnt0));
            check_eq("stat_grant1", AES_W'(stat_grant1), AES_W'(cnt1));
        end
`endif
        if (er0) begin
            sb.push_back('{id: 1'b0, data: vc[vi0], due: now + LAT});
            vi0    = (vi0 + 1) % NV;
            prio_m = 1'b1;
            if (cnt0 != 32'hFFFF_FFFF) cnt0++;
        end
        if (er1) begin
            sb.push_back('{id: 1'b1, data: vc[vi1], due: now + LAT});
            vi1    = (vi1 + 1) % NV;
            prio_m = 1'b0;
            if (cnt1 != 32'hFFFF_FFFF) cnt1++;
        end
        if (r) begin
            sb.delete();
            prio_m = 1'b0;
            cnt0   = 0;
            cnt1   = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        vk[0] = 128'h000102030405060708090a0b0c0d0e0f;
        vp[0] = 128'h00112233445566778899aabbccddeeff;
        vc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vp[1] = 128'h3243f6a8885a308d313198a2e0370734;
        vc[1] = 128'h3925841d02dc09fbdc118597196a0b32;
        vk[2] = 128'h0;
        vp[2] = 128'h0;
        vc[2] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        vk[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vp[3] = 128'h6bc1bee22e409f96e93d7e117393172a;
        vc[3] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        vk[4] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vp[4] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        vc[4] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        vk[5] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vp[5] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        vc[5] = 128'h43b1cd7f598ece23881b00e3ed030688;
        vk[6] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vp[6] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        vc[6] = 128'h7b0c785e27e8ad3f8223207104725dd4;

        // Reset, then a single FIPS-197 job on requester 0.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(LAT + 3);

        // Both requesters for 10 cycles from a fresh pointer.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        peak = 0;
        repeat (10) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        idle(LAT + 2);
        check_eq("peak_both", AES_W'(peak), AES_W'(10));

        // Requester 0 streaming for 40 cycles: in_flight saturates at LAT.
        peak = 0;
        repeat (40) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(LAT + 2);
        check_eq("peak_stream", AES_W'(peak), AES_W'(LAT));

        // Reset with 5 jobs in flight discards them.
        repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        idle(LAT + 3);

        // en dropped while both requesters stay valid.
        repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        idle(LAT + 2);

        // Random traffic with occasional enable drops and resets.
        repeat (80) cyc(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(LAT + 2);

`ifdef AES_128_SCHED_STATS_EN
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("stat0_seven", AES_W'(stat_grant0), AES_W'(7));
        check_eq("stat1_three", AES_W'(stat_grant1), AES_W'(3));
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("stat0_rst", AES_W'(stat_grant0), AES_W'(0));
        check_eq("stat1_rst", AES_W'(stat_grant1), AES_W'(0));
        idle(LAT + 2);
`endif

        check_eq("sb_empty", AES_W'(sb.size()), AES_W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_128_sched.md
AES_128_SCHED -- requirements
Module: aes_128_sched

Interface
REQ-001 Parameter AES_LATENCY, default 21: clk edges from input capture to valid output of the aes_128 core.
REQ-002 Port clk, input, 1: single clock; all logic on rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port en, input, 1: when low, no new grants are issued; in-flight jobs still complete.
REQ-005 Ports req0_valid / req1_valid, input, 1: requester has a job.
REQ-006 Ports req0_ready / req1_ready, output, 1: job accepted this cycle when valid&ready.
REQ-007 Ports req0_state / req1_state, input, 128: plaintext.
REQ-008 Ports req0_key / req1_key, input, 128: key.
REQ-009 Ports resp0_valid / resp1_valid, output, 1: one-cycle pulse, ciphertext for that requester.
REQ-010 Ports resp0_data / resp1_data, output, 128: ciphertext.
REQ-011 Port in_flight, output, 5: count of accepted jobs not yet returned.
REQ-012 Port busy, output, 1: high iff in_flight != 0.

Function
REQ-013 Shall share one internal fully pipelined aes_128 core between two requesters, at most one accept per cycle.
REQ-014 req_ready shall be combinational: high only for the granted requester, only when en=1 and that requester's valid=1.
REQ-015 Arbitration shall be round-robin: single valid requester always granted; both valid -> grant the one not granted at the last accept; rr pointer updates only on an accept.
REQ-016 Accepted job's state/key shall drive the core inputs that cycle; with no accept the core inputs shall be driven to all-zero.
REQ-017 A tag pipeline (valid bit + requester id) of depth AES_LATENCY shall shift every cycle, stage 0 loaded with {accept, granted id}.
REQ-018 A job accepted at edge N shall produce respX_valid=1 with respX_data=core out in the cycle after edge N+AES_LATENCY-1 (exactly AES_LATENCY cycles later), only for the owning requester.
REQ-019 respX_data shall be zero whenever respX_valid=0.
REQ-020 Responses have no backpressure; back-to-back accepts yield back-to-back responses in accept order.
REQ-021 in_flight shall increment on accept, decrement on response, be unchanged on simultaneous accept+response; range 0..AES_LATENCY, never wraps.
REQ-022 en deasserted mid-stream: ready drops the same cycle, pending results still emerge on schedule.

Reset
REQ-023 While rst=1: rr pointer -> requester 0, tag pipeline cleared, in_flight=0, busy=0, all resp_valid=0, all resp_data=0, all req_ready=0.
REQ-024 Reset mid-operation shall discard all in-flight jobs; no response pulses for them after rst deasserts, even though the core's data pipeline is not reset.

Configuration
REQ-025 Macro AES_128_SCHED_STATS_EN defined: adds outputs stat_grant0, stat_grant1 (32 bit each), counting accepts per requester, saturating at 0xFFFFFFFF, cleared by rst.
REQ-026 Macro undefined: those ports and counters shall not exist; all other behaviour identical.

Structure
REQ-027 Package aes_128_sched_pkg shall hold AES_W=128, default latency 21, requester-id width, and the in_flight width.
REQ-028 Sole sub-module: existing aes_128 core instance (clk, state, key, out); arbiter and tag pipeline stay in-module.

Verification
REQ-029 Single job: req0 key=000102030405060708090a0b0c0d0e0f, state=00112233445566778899aabbccddeeff -> resp0_valid exactly 21 cycles later, data=69c4e0d86a7b0430d8cdb78070b4c55a; resp1_valid never high.
REQ-030 Both requesters valid continuously for 10 cycles -> grants alternate 0,1,0,1...; 10 responses on alternating ports, in order, each 21 cycles after its accept; in_flight peaks at 10.
REQ-031 Continuous req0 only for 40 cycles -> in_flight saturates at 21 and holds (accept+response each cycle); busy stays high until 21 cycles after last accept.
REQ-032 rst pulsed one cycle with 5 jobs in flight -> in_flight=0 next cycle, no resp_valid pulses for the next 21 cycles.
REQ-033 en dropped with both valid -> both ready low that cycle; already-accepted jobs still respond on schedule; busy falls after the last one.
REQ-034 With AES_128_SCHED_STATS_EN: 7 accepts on req0, 3 on req1 -> stat_grant0=7, stat_grant1=3; zero after rst.
